// File: rtl/add16_seq_ctrl.sv
// add16_seq_ctrl: 16-bit add/subtract sequenced as four nibbles through an external shared 4-bit adder
// Ports: clk, rst (async, active-high); start/A/B/Cin/Sub request an operation, captured in IDLE;
//        busy (RUN), done (one-cycle pulse), S/Cout/Ovf registered result;
//        add_A/add_B/add_Cin drive the external adder, add_S/add_Cout come back from it.
module add16_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    input  logic        Sub,
    output logic        busy,
    output logic        done,
    output logic [15:0] S,
    output logic        Cout,
    output logic        Ovf,
    output logic [3:0]  add_A,
    output logic [3:0]  add_B,
    output logic        add_Cin,
    input  logic [3:0]  add_S,
    input  logic        add_Cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  idx_q;
    logic        carry_q, cout_q, ovf_q;
    logic [15:0] a_q, b_q, work_q, s_q;
    always_comb begin
        state_d = IDLE;
        state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
                  (state_q == RUN)  ? (idx_q == 2'd3 ? DONE : RUN) : IDLE;
    end
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign add_A   = busy ? a_q[{idx_q, 2'b00} +: 4] : 4'd0;
    assign add_B   = busy ? b_q[{idx_q, 2'b00} +: 4] : 4'd0;
    assign add_Cin = busy & carry_q;
    assign S       = s_q;
    assign Cout    = cout_q;
    assign Ovf     = ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            work_q  <= 16'd0;
            s_q     <= 16'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                a_q     <= A;
                b_q     <= Sub ? ~B : B;
                carry_q <= Sub | Cin;
                idx_q   <= 2'd0;
            end else if (state_q == RUN) begin
                work_q[{idx_q, 2'b00} +: 4] <= add_S;
                carry_q <= add_Cout;
                idx_q   <= idx_q + 2'd1;
                // last nibble goes straight into S; work only holds the lower three
                if (idx_q == 2'd3) begin
                    s_q    <= {add_S, work_q[11:0]};
                    cout_q <= add_Cout;
                    ovf_q  <= (a_q[15] == b_q[15]) && (add_S[3] != a_q[15]);
                end
            end
        end
    end
endmodule

// File: doc/add16_seq_ctrl.md
ADD16_SEQ_CTRL -- requirements
Module: add16_seq_ctrl

Interface
REQ-001 Parameters: none; the block SHALL be fixed at 16-bit operands sequenced as four 4-bit nibbles.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 A  input  16  operand A, captured on the accepting edge.
REQ-006 B  input  16  operand B, captured on the accepting edge.
REQ-007 Cin  input  1  carry-in for add, captured on the accepting edge.
REQ-008 Sub  input  1  1 = compute A-B (Cin ignored), captured on the accepting edge.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  single-cycle pulse; result valid.
REQ-011 S  output  16  registered result.
REQ-012 Cout  output  1  registered carry out of bit 15.
REQ-013 Ovf  output  1  registered signed overflow.
REQ-014 add_A  output  4  nibble A to the external shared 4-bit ripple adder.
REQ-015 add_B  output  4  nibble B (post-inversion) to the adder.
REQ-016 add_Cin  output  1  carry into the adder.
REQ-017 add_S  input  4  adder sum, combinational from add_A/add_B/add_Cin.
REQ-018 add_Cout  input  1  adder carry-out.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE; a 2-bit nibble index idx SHALL be kept.
REQ-020 IDLE & start=1 at an edge: capture Aq=A, Bq=(Sub ? ~B : B), carry=(Sub ? 1 : Cin), idx=0, go to RUN.
REQ-021 IDLE & start=0: stay IDLE; no register changes.
REQ-022 In RUN, add_A=Aq[4*idx+3:4*idx], add_B=Bq[4*idx+3:4*idx], add_Cin=carry (combinational from registers).
REQ-023 Outside RUN, add_A, add_B, add_Cin SHALL be driven 0.
REQ-024 Each RUN edge: work[4*idx+3:4*idx]<=add_S, carry<=add_Cout, idx<=idx+1.
REQ-025 RUN edge with idx=3: instead of wrapping, go to DONE and load S<={add_S,work[11:0]}, Cout<=add_Cout, Ovf<=(Aq[15]==Bq[15]) & (add_S[3]!=Aq[15]).
REQ-026 DONE: done=1 for exactly that cycle; next edge returns to IDLE unconditionally.
REQ-027 Latency: done SHALL be high in the 5th cycle after the accepting edge (4 RUN cycles, then DONE); max throughput one op per 6 cycles.
REQ-028 start in RUN or DONE SHALL be ignored and not queued; A/B/Cin/Sub changes after capture SHALL NOT affect the result.
REQ-029 S, Cout, Ovf SHALL hold their last values from the DONE load until the next DONE load; they SHALL NOT change during RUN.
REQ-030 busy=1 only in RUN; done=1 only in DONE; never both high.

Reset
REQ-031 rst=1 SHALL immediately (no clock) force IDLE, idx=0, carry=0, Aq=Bq=work=0, S=0, Cout=0, Ovf=0, busy=0, done=0.
REQ-032 rst asserted mid-RUN or in DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-033 On the first edge after rst deasserts, start=1 SHALL be accepted normally.

Verification
REQ-034 Add: A=0x1234, B=0x1111, Cin=0, Sub=0 -> done in 5th cycle after accept, S=0x2345, Cout=0, Ovf=0; add_A sequence 4,3,2,1 across RUN cycles.
REQ-035 Full ripple: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, Ovf=0; add_Cin=0,1,1,1 across RUN cycles.
REQ-036 Sub: A=0x8000, B=0x0001, Sub=1, Cin=0 -> S=0x7FFF, Cout=1, Ovf=1; add_Cin=1 in first RUN cycle.
REQ-037 Signed overflow add: A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, Ovf=1; Cin=1 with A=B=0 -> S=0x0001.
REQ-038 start held high continuously and A/B changed during RUN -> exactly one done per accepted op, results match operands at accept edges, next accept one cycle after DONE.
REQ-039 rst pulsed during the 2nd RUN cycle of A=0x1234,B=0x1111 -> outputs 0 immediately, no done; subsequent op completes correctly.
